// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter that lets CPUS cache pairs (one data
// and one instruction requester each) share a single RAM port.
// Requester r = 2c is cpu c's data side; r = 2c+1 is its instruction side.
// Optional grant timeout: define MEMORY_ARBITER_TIMEOUT_EN to enable it.
// Without it, a grant stays active until the RAM reports ACCESS or the
// requester drops its request.

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

module memory_arbiter #(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CPUS-1:0]           iREN,
  input  logic [CPUS-1:0]           dREN,
  input  logic [CPUS-1:0]           dWEN,
  input  logic [CPUS*32-1:0]        iaddr,
  input  logic [CPUS*32-1:0]        daddr,
  input  logic [CPUS*32-1:0]        dstore,
  output logic [CPUS-1:0]           iwait,
  output logic [CPUS-1:0]           dwait,
  output logic [CPUS*32-1:0]        iload,
  output logic [CPUS*32-1:0]        dload,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [31:0]               ramaddr,
  output logic [31:0]               ramstore,
  input  logic [31:0]               ramload,
  input  cpu_types_pkg::ramstate_t  ramstate,
  output logic                      timeout_err
);

  localparam int NREQ = 2 * CPUS;
  localparam int PW   = $clog2(NREQ);

  // Refuse to elaborate with parameters outside the supported range.
  if (CPUS < 1 || CPUS > 4 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_badParams
    $error("memory_arbiter: CPUS must be 1..4 and TIMEOUT 2..255");
  end

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_grant;

  logic [NREQ-1:0] w_reqActive;
  logic            w_anyActive;
  logic [PW-1:0]   w_winner;
  logic            w_found;
  int              w_idx;

  logic            w_gIsInstr;
  logic            w_selIren;
  logic            w_selDren;
  logic            w_selDwen;
  logic [31:0]     w_selIaddr;
  logic [31:0]     w_selDaddr;
  logic [31:0]     w_selDstore;
  logic            w_gActive;
  logic            w_inActive;
  logic            w_access;
  logic            w_complete;
  logic            w_timeout;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic [7:0]      r_count;
`endif

  // Flatten per-cpu request lines into the requester index space.
  always_comb begin
    w_reqActive = '0;
    for (int c = 0; c < CPUS; c++) begin
      w_reqActive[2*c]   = dREN[c] | dWEN[c];
      w_reqActive[2*c+1] = iREN[c];
    end
  end

  assign w_anyActive = |w_reqActive;

  // Round-robin search: first active requester strictly after r_ptr, wrapping.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && w_reqActive[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PW-1:0];
      end
    end
  end

  assign w_gIsInstr = r_grant[0];

  // Select the granted cpu's request lines, address and store word.
  always_comb begin
    w_selIren   = 1'b0;
    w_selDren   = 1'b0;
    w_selDwen   = 1'b0;
    w_selIaddr  = '0;
    w_selDaddr  = '0;
    w_selDstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      if ((int'(r_grant) >> 1) == c) begin
        w_selIren   = iREN[c];
        w_selDren   = dREN[c];
        w_selDwen   = dWEN[c];
        w_selIaddr  = iaddr[32*c +: 32];
        w_selDaddr  = daddr[32*c +: 32];
        w_selDstore = dstore[32*c +: 32];
      end
    end
  end

  assign w_gActive  = w_gIsInstr ? w_selIren : (w_selDren | w_selDwen);
  assign w_inActive = (r_state == ACTIVE);
  assign w_access   = (ramstate == cpu_types_pkg::ACCESS);
  assign w_complete = w_inActive & w_gActive & w_access;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  assign w_timeout = w_inActive & w_gActive & ~w_access
                   & (r_count == 8'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign timeout_err = w_timeout;

  // Every cpu sees the RAM read word; only the one whose wait drops uses it.
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  // Drive the RAM port from the granted requester; a write wins over a read.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (w_inActive) begin
      if (w_gIsInstr) begin
        ramREN  = w_selIren;
        ramaddr = w_selIaddr;
      end else begin
        ramWEN   = w_selDwen;
        ramREN   = w_selDren & ~w_selDwen;
        ramaddr  = w_selDaddr;
        ramstore = w_selDstore;
      end
    end
  end

  // Only the granted requester's wait drops, and only on the ACCESS cycle.
  always_comb begin
    iwait = '1;
    dwait = '1;
    for (int c = 0; c < CPUS; c++) begin
      if (w_complete && ((int'(r_grant) >> 1) == c)) begin
        if (w_gIsInstr) begin
          iwait[c] = 1'b0;
        end else begin
          dwait[c] = 1'b0;
        end
      end
    end
  end

  // Arbitration FSM: grant in IDLE, hold in ACTIVE until done, dropped or timed out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr   <= PW'(NREQ - 1);
      r_grant <= '0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      r_count <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyActive) begin
            r_grant <= w_winner;
            r_state <= ACTIVE;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
            r_count <= '0;
`endif
          end
        end
        ACTIVE: begin
          if (!w_gActive) begin
            r_state <= IDLE;
          end else if (w_access) begin
            r_ptr   <= r_grant;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_ptr   <= r_grant;
            r_state <= IDLE;
          end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          else begin
            r_count <= r_count + 8'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of memory_arbiter with CPUS=2, TIMEOUT=4.
// Inputs change 1ns after the rising edge; outputs are compared 1ns later.

module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS    = 2;
  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] expAddr [5];
  logic [1:0]  expIw   [5];
  logic [1:0]  expDw   [5];

  memory_arbiter #(.CPUS(CPUS), .TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iREN       (iREN),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .iaddr      (iaddr),
    .daddr      (daddr),
    .dstore     (dstore),
    .iwait      (iwait),
    .dwait      (dwait),
    .iload      (iload),
    .dload      (dload),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ramstate   (ramstate),
    .timeout_err(timeout_err)
  );

  // Free-running 10ns clock.
  always #5 CLK = ~CLK;

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] dr, input logic [1:0] dw,
                               input logic [1:0] ir, input ramstate_t st);
    dREN     = dr;
    dWEN     = dw;
    iREN     = ir;
    ramstate = st;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBus(input string tag, input logic expRen, input logic expWen,
                          input logic [31:0] expA, input logic [1:0] expI,
                          input logic [1:0] expD);
    checkOutput({tag, "_ren"},   64'(ramREN),  64'(expRen));
    checkOutput({tag, "_wen"},   64'(ramWEN),  64'(expWen));
    checkOutput({tag, "_addr"},  64'(ramaddr), 64'(expA));
    checkOutput({tag, "_iwait"}, 64'(iwait),   64'(expI));
    checkOutput({tag, "_dwait"}, 64'(dwait),   64'(expD));
  endtask

  initial begin
    // Reset with requests pending: nothing may reach the RAM port.
    RST      = 1'b1;
    iREN     = 2'b00;
    dREN     = 2'b11;
    dWEN     = 2'b00;
    iaddr    = {32'h0000_00C0, 32'h0000_0100};
    daddr    = {32'h0000_00B0, 32'h0000_00A0};
    dstore   = {32'h1111_2222, 32'h3333_4444};
    ramload  = 32'h0;
    ramstate = BUSY;
    nextCycle();
    nextCycle();
    checkBus("reset", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    checkOutput("reset_store", 64'(ramstore), 64'h0);
    checkOutput("reset_tmo", 64'(timeout_err), 64'h0);

    // Single instruction read: enables from the cycle after the request.
    RST = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b01, BUSY);
    checkOutput("lat_idle_ren", 64'(ramREN), 64'h0);
    nextCycle();
    checkBus("irdBusy1", 1'b1, 1'b0, 32'h100, 2'b11, 2'b11);
    checkOutput("irdBusy1_store", 64'(ramstore), 64'h0);
    nextCycle();
    checkBus("irdBusy2", 1'b1, 1'b0, 32'h100, 2'b11, 2'b11);
    nextCycle();
    ramload = 32'h1234_5678;
    applyStimulus(2'b00, 2'b00, 2'b01, ACCESS);
    checkBus("irdAccess", 1'b1, 1'b0, 32'h100, 2'b10, 2'b11);
    checkOutput("irdAccess_iload", iload, 64'h1234_5678_1234_5678);
    checkOutput("irdAccess_dload", dload, 64'h1234_5678_1234_5678);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, FREE);
    checkBus("irdDone", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);

    // Fresh reset so requester 0 wins first, then full round robin.
    RST = 1'b1;
    nextCycle();
    RST = 1'b0;
    expAddr = '{32'h0A0, 32'h100, 32'h0B0, 32'h0C0, 32'h0A0};
    expIw   = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    expDw   = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10};
    applyStimulus(2'b11, 2'b00, 2'b11, ACCESS);
    checkBus("rrStart", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkBus($sformatf("rrGrant%0d", i), 1'b1, 1'b0, expAddr[i], expIw[i], expDw[i]);
      nextCycle();
      if (i == 4) applyStimulus(2'b00, 2'b00, 2'b00, FREE);
      checkBus($sformatf("rrBubble%0d", i), 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    end

    // Write with dREN and dWEN both high on cpu 1 (pointer now at r0 -> r2 wins).
    daddr  = {32'h0000_0200, 32'h0000_00A0};
    dstore = {32'hDEAD_BEEF, 32'h3333_4444};
    applyStimulus(2'b10, 2'b10, 2'b00, BUSY);
    checkOutput("wrIdle_wen", 64'(ramWEN), 64'h0);
    nextCycle();
    checkBus("wrBusy", 1'b0, 1'b1, 32'h200, 2'b11, 2'b11);
    checkOutput("wrBusy_store", 64'(ramstore), 64'hDEAD_BEEF);
    applyStimulus(2'b10, 2'b10, 2'b00, ACCESS);
    checkBus("wrAccess", 1'b0, 1'b1, 32'h200, 2'b11, 2'b01);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, FREE);
    checkBus("wrDone", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);

    // Reset mid-transaction; afterwards requester 0 must win again.
    daddr = {32'h0000_0200, 32'h0000_0300};
    applyStimulus(2'b01, 2'b00, 2'b00, BUSY);
    nextCycle();
    checkBus("preRst", 1'b1, 1'b0, 32'h300, 2'b11, 2'b11);
    RST = 1'b1;
    #1;
    checkBus("midRst", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    checkOutput("midRst_store", 64'(ramstore), 64'h0);
    applyStimulus(2'b11, 2'b00, 2'b11, ACCESS);
    nextCycle();
    checkBus("heldRst", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    RST = 1'b0;
    #1;
    checkBus("rstRelease", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    nextCycle();
    checkBus("postRstGrant", 1'b1, 1'b0, 32'h300, 2'b11, 2'b10);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, FREE);
    checkBus("postRstIdle", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);

    // Granted instruction request on cpu 1 drops mid-grant; pointer stays.
    iaddr = {32'h0000_0400, 32'h0000_0100};
    daddr = {32'h0000_0200, 32'h0000_0500};
    applyStimulus(2'b00, 2'b00, 2'b10, BUSY);
    nextCycle();
    checkBus("dropGrant", 1'b1, 1'b0, 32'h400, 2'b11, 2'b11);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, ACCESS);
    checkBus("dropped", 1'b0, 1'b0, 32'h400, 2'b11, 2'b11);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 2'b10, BUSY);
    checkBus("dropIdle", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    nextCycle();
    checkBus("dropRegrant", 1'b1, 1'b0, 32'h400, 2'b11, 2'b11);
    applyStimulus(2'b01, 2'b00, 2'b10, ACCESS);
    checkBus("dropRegrantAcc", 1'b1, 1'b0, 32'h400, 2'b01, 2'b11);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, FREE);
    checkBus("dropDone", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);

    // RAM stuck BUSY with r0 and r2 requesting (pointer at r3 -> r0 wins).
    daddr = {32'h0000_0600, 32'h0000_0500};
    applyStimulus(2'b11, 2'b00, 2'b00, BUSY);
    checkOutput("stuckIdle_ren", 64'(ramREN), 64'h0);
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      checkBus($sformatf("tmoCycle%0d", i), 1'b1, 1'b0, 32'h500, 2'b11, 2'b11);
      checkOutput($sformatf("tmoCycle%0d_err", i), 64'(timeout_err), 64'(i == 4));
    end
    nextCycle();
    checkBus("tmoBubble", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11);
    checkOutput("tmoBubble_err", 64'(timeout_err), 64'h0);
    nextCycle();
    checkBus("tmoNext", 1'b1, 1'b0, 32'h600, 2'b11, 2'b11);
`else
    for (int i = 1; i <= 6; i++) begin
      nextCycle();
      checkBus($sformatf("stuckCycle%0d", i), 1'b1, 1'b0, 32'h500, 2'b11, 2'b11);
      checkOutput($sformatf("stuckCycle%0d_err", i), 64'(timeout_err), 64'h0);
    end
`endif
    applyStimulus(2'b00, 2'b00, 2'b00, FREE);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter CPUS, default 2, number of cache pairs arbitrated (legal 1..4).
REQ-002 Parameter TIMEOUT, default 64, max cycles one grant may wait for ACCESS (legal 2..255).
REQ-003 CLK  in  1  single clock, rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 iREN  in  CPUS  per-cpu instruction read request.
REQ-006 dREN, dWEN  in  CPUS each  per-cpu data read / write request.
REQ-007 iaddr, daddr, dstore  in  CPUS*32 each  per-cpu address/store word, cpu c at bits [32c+31:32c].
REQ-008 iwait, dwait  out  CPUS each  per-cpu wait, 0 only on the completing cycle.
REQ-009 iload, dload  out  CPUS*32 each  per-cpu load word.
REQ-010 ramREN, ramWEN  out  1 each  RAM read/write enable.
REQ-011 ramaddr, ramstore  out  32 each  RAM address / write data.
REQ-012 ramload  in  32  RAM read data; ramstate  in  2  FREE/BUSY/ACCESS/ERROR (cpu_types_pkg).
REQ-013 timeout_err  out  1  one-cycle pulse on grant timeout.

Function
REQ-014 Requesters SHALL be indexed r=2c (data, cpu c) and r=2c+1 (instr, cpu c), 2*CPUS total; requester active when (dREN|dWEN) or iREN respectively.
REQ-015 FSM states SHALL be IDLE and ACTIVE only.
REQ-016 IDLE: ramREN=ramWEN=0; if any requester active, winner = first active index after ptr, searching upward modulo 2*CPUS; grant registered, next state ACTIVE.
REQ-017 Latency: request first high in cycle N from IDLE SHALL drive RAM enables from cycle N+1.
REQ-018 ACTIVE: ramaddr, ramREN/ramWEN, ramstore SHALL come combinationally from the granted requester; instr grant drives ramstore=0, ramWEN=0.
REQ-019 dWEN and dREN both high on one cpu SHALL be a write: ramWEN=1, ramREN=0.
REQ-020 ACTIVE with ramstate==ACCESS: granted wait SHALL be 0 that cycle; ptr<=grant; next state IDLE.
REQ-021 ACTIVE with FREE, BUSY or ERROR: all waits 1, remain ACTIVE.
REQ-022 Granted requester dropping its request in ACTIVE: next state IDLE, no wait deassertion, ptr unchanged.
REQ-023 Exactly one IDLE bubble cycle SHALL separate back-to-back grants.
REQ-024 All waits not covered by REQ-020 SHALL be 1; at most one wait bit low per cycle.
REQ-025 iload and dload for every cpu SHALL equal ramload combinationally.
REQ-026 Non-granted requests SHALL be held pending, never dropped by the arbiter; no requester waits more than 2*CPUS-1 grants.

Reset
REQ-027 RST high SHALL immediately force IDLE, ptr=2*CPUS-1 (requester 0 wins first), timeout counter 0.
REQ-028 During reset: all waits 1, ramREN=ramWEN=0, ramaddr=ramstore=0, timeout_err=0.
REQ-029 Reset mid-ACTIVE SHALL abandon the transaction with no wait deassertion; arbitration restarts one cycle after RST falls.

Configuration
REQ-030 Macro MEMORY_ARBITER_TIMEOUT_EN defined: 8-bit counter clears on entering ACTIVE and increments each ACTIVE cycle without ACCESS; at count TIMEOUT-1 without ACCESS, timeout_err=1 that cycle, ptr<=grant, next state IDLE, granted wait stays 1.
REQ-031 Macro undefined: no counter, timeout_err tied 0, ACTIVE held indefinitely until ACCESS or request drop.

Verification (CPUS=2, TIMEOUT=4)
REQ-032 Reset release, iREN[0]=1 iaddr0=0x100, ramstate BUSY 2 cycles then ACCESS -> ramREN=1 ramaddr=0x100 from cycle 1; iwait[0]=0 only on ACCESS cycle; iload0=ramload.
REQ-033 dREN[0],iREN[0],dREN[1],iREN[1] all held, ACCESS every ACTIVE cycle -> grant order r0,r1,r2,r3,r0 with one IDLE cycle between each.
REQ-034 dWEN[1]=dREN[1]=1 daddr1=0x200 dstore1=0xDEADBEEF -> ramWEN=1 ramREN=0 ramaddr=0x200 ramstore=0xDEADBEEF; dwait[1]=0 on ACCESS.
REQ-035 RST asserted during ACTIVE BUSY -> same cycle ramREN=ramWEN=0, all waits 1; after release requester 0 wins first.
REQ-036 TIMEOUT_EN defined, ramstate stuck BUSY -> timeout_err pulses in 4th ACTIVE cycle, next grant goes to next active index; undefined -> ACTIVE persists, timeout_err=0.
REQ-037 Granted iREN[1] dropped mid-ACTIVE -> IDLE next cycle, iwait[1] never 0, ptr unchanged.
